// File: rtl/run_sequencer_pkg.sv
// Shared types and default parameters for the run sequencer and its bench.
package run_seq_pkg;

    localparam int CW_DEF      = 16;
    localparam int RST_CYC_DEF = 2;
    localparam int TMO_DEF     = 1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RSTC = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } run_state_t;

endpackage

// File: rtl/run_sequencer_cycle_ctr.sv
// Clearable, enabled up-counter with a terminal-count flag at a fixed value.
module run_cycle_ctr #(
    parameter int              CW = 16,
    parameter logic [CW-1:0]   TC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over enable so a fresh run always starts from zero.
    always_comb begin
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC);

endmodule

// File: rtl/run_sequencer.sv
// Run controller: core reset pulse, run-enable window, cycle count and watchdog.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int RST_CYC = RST_CYC_DEF,
    parameter int TMO     = TMO_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    run_state_t    state_q, state_d;
    logic          timeout_q, timeout_d;
    logic          core_reset_q, core_en_q, busy_q, done_q;
    logic          start_s;
    logic          hold_tc_s;
    logic [CW-1:0] hold_cnt_unused_s;
    logic          cyc_tc_s;
    logic [CW-1:0] cyc_cnt_s;

    assign start_s = (state_q == ST_IDLE) && req;

    run_cycle_ctr #(.CW(CW), .TC(CW'(RST_CYC - 1))) u_hold_ctr (
        .clk   (clk),
        .rst   (reset),
        .clr_i (start_s),
        .en_i  (state_q == ST_RSTC),
        .cnt_o (hold_cnt_unused_s),
        .tc_o  (hold_tc_s)
    );

    // cycles counts every RUN edge, the exit edge included, so it lands on TMO at watchdog expiry.
    run_cycle_ctr #(.CW(CW), .TC(CW'(TMO - 1))) u_cyc_ctr (
        .clk   (clk),
        .rst   (reset),
        .clr_i (start_s),
        .en_i  (state_q == ST_RUN),
        .cnt_o (cyc_cnt_s),
        .tc_o  (cyc_tc_s)
    );

    // Next-state logic; a dropped req beats everything, core_done beats the watchdog.
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d   = ST_RSTC;
                    timeout_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RSTC: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (hold_tc_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_RSTC;
                end
            end
            ST_RUN: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (core_done) begin
                    state_d   = ST_FIN;
                    timeout_d = 1'b0;
                end else if (cyc_tc_s) begin
                    state_d   = ST_FIN;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIN: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                timeout_d = 1'b0;
            end
        endcase
    end

    // State and Moore outputs, registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timeout_q    <= 1'b0;
            core_reset_q <= 1'b1;
            core_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timeout_q    <= timeout_d;
            core_reset_q <= (state_d == ST_IDLE) || (state_d == ST_RSTC);
            core_en_q    <= (state_d == ST_RUN);
            busy_q       <= (state_d == ST_RSTC) || (state_d == ST_RUN);
            done_q       <= (state_d == ST_FIN);
        end
    end

    assign core_reset = core_reset_q;
    assign core_en    = core_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign cycles     = cyc_cnt_s;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomised scoreboard bench for run_sequencer with a run-level reference model.
module tb_run_sequencer;
    import run_seq_pkg::*;

    localparam int CW  = CW_DEF;
    localparam int RC  = RST_CYC_DEF;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic          core_done = 1'b0;
    logic          core_reset, core_en, busy, done, timeout;
    logic [CW-1:0] cycles;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit is_done;
        bit to;
        int cyc;
        bit chk_en;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    run_sequencer #(.CW(CW), .RST_CYC(RC), .TMO(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .core_done  (core_done),
        .core_reset (core_reset),
        .core_en    (core_en),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycles     (cycles)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: a run ends either with done rising or with busy dropping without done.
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    int   en_cnt = 0;
    always @(negedge clk) begin : mon
        int   n;
        exp_t e;
        n = (busy === 1'b1 && prev_busy !== 1'b1) ? 0 : en_cnt;
        if (core_en === 1'b1) n++;
        if ((done === 1'b1 && prev_done !== 1'b1) ||
            (prev_busy === 1'b1 && busy !== 1'b1 && done !== 1'b1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_run_end", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("end_kind_done", done, e.is_done);
                chk("end_cycles", cycles, e.cyc);
                if (e.is_done) begin
                    chk("end_timeout", timeout, e.to);
                    chk("end_core_en", core_en, 1'b0);
                end
                if (e.chk_en) chk("enabled_cycles", n, e.cyc);
            end
        end
        en_cnt    <= n;
        prev_busy <= busy;
        prev_done <= done;
    end

    // n = RUN edge carrying core_done (0: never); ab > 0 drops req at that RUN edge, ab < 0 in RSTC.
    task automatic do_run(input int n, input int ab);
        exp_t e;
        int   fin_k;
        int   end_k;
        fin_k = (n >= 1 && n <= TMO) ? n : TMO;
        if (ab < 0) begin
            e.is_done = 1'b0; e.to = 1'b0; e.cyc = 0;
        end else if (ab > 0 && ab <= fin_k) begin
            e.is_done = 1'b0; e.to = 1'b0; e.cyc = ab;
        end else begin
            e.is_done = 1'b1; e.to = (n < 1 || n > TMO); e.cyc = fin_k;
        end
        e.chk_en = 1'b1;
        sb.push_back(e);
        end_k = e.is_done ? fin_k : ab;

        req = 1'b1;
        for (int k = 0; k <= RC; k++) begin
            core_done = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (k == 0) chk("entry_cycles_clear", cycles, 32'd0);
            if (k < RC) begin
                chk("rstc_core_reset", core_reset, 1'b1);
                chk("rstc_core_en", core_en, 1'b0);
                chk("rstc_busy", busy, 1'b1);
                if (ab < 0) begin
                    req = 1'b0;
                    core_done = 1'b0;
                    @(posedge clk); #1;
                    chk("rstc_abort_core_reset", core_reset, 1'b1);
                    chk("rstc_abort_busy", busy, 1'b0);
                    chk("rstc_abort_core_en", core_en, 1'b0);
                    return;
                end
            end else begin
                chk("run_core_reset", core_reset, 1'b0);
                chk("run_core_en", core_en, 1'b1);
            end
        end

        for (int k = 1; k <= end_k; k++) begin
            if (ab == k) req = 1'b0;
            core_done = (k == n);
            @(posedge clk); #1;
            if (k < end_k) chk("run_cycles", cycles, k);
        end
        core_done = 1'b0;
        if (!e.is_done) begin
            chk("abort_core_reset", core_reset, 1'b1);
            chk("abort_done", done, 1'b0);
            chk("abort_busy", busy, 1'b0);
            return;
        end
        chk("fin_core_reset", core_reset, 1'b0);
        chk("fin_busy", busy, 1'b0);
        repeat (2) begin
            core_done = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("fin_hold_cycles", cycles, e.cyc);
            chk("fin_hold_done", done, 1'b1);
        end
        core_done = 1'b0;
        req = 1'b0;
        @(posedge clk); #1;
        chk("drop_done", done, 1'b0);
        chk("drop_core_reset", core_reset, 1'b1);
        chk("idle_cycles", cycles, e.cyc);
        chk("idle_timeout", timeout, e.to);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded limit 200000", $time);
        $fatal(1, "bench hung");
    end

    initial begin : stim
        exp_t rst_e;
        int   n;
        int   r;
        int   ab;

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_core_reset", core_reset, 1'b1);
        chk("rst_core_en", core_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_cycles", cycles, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        do_run(10, 0);
        do_run(0, 0);
        do_run(TMO, 0);
        do_run(12, 5);
        do_run(10, -1);
        do_run(7, 0);
        do_run(3, 0);

        // Reset in the middle of RUN: everything returns to reset values without an edge.
        rst_e.is_done = 1'b0; rst_e.to = 1'b0; rst_e.cyc = 0; rst_e.chk_en = 1'b0;
        sb.push_back(rst_e);
        req = 1'b1;
        repeat (RC + 1 + 4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midrun_rst_core_reset", core_reset, 1'b1);
        chk("midrun_rst_core_en", core_en, 1'b0);
        chk("midrun_rst_busy", busy, 1'b0);
        chk("midrun_rst_cycles", cycles, 32'd0);
        req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        do_run(4, 0);

        for (int i = 0; i < 12; i++) begin
            n = $urandom_range(0, TMO + 3);
            r = $urandom_range(0, 9);
            ab = (r == 0) ? -1 : (r == 1) ? int'($urandom_range(1, TMO)) : 0;
            do_run(n, ab);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Run controller for the single-cycle core. It turns the external `req`/`done` handshake into a core-reset pulse, a run-enable window and a completion report. It counts the cycles each program takes and aborts runaway programs with a watchdog. It sits between the bench or host and the core's `reset` and PC-enable inputs, and watches the core's program-end compare (`prog_ctr == end address`).

## Interface
- `CW`, 16: width of the cycle counter.
- `RST_CYC`, 2: number of cycles the core is held in reset before each run; must be ≥1.
- `TMO`, 1000: watchdog limit, in RUN cycles; must be ≥2 and ≤ 2^CW−1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces every output to its reset value immediately, without waiting for a clock edge.
- `req`  in  1  run request, level; held high for the whole run.
- `core_done`  in  1  from the core's program-end compare.
- `core_reset`  out  1  synchronous reset to the PC and register file.
- `core_en`  out  1  PC advance / RegWrite / MemWrite qualifier.
- `busy`  out  1  high in the RSTC and RUN states.
- `done`  out  1  run finished; held until `req` falls.
- `timeout`  out  1  qualifies `done`: the run ended on the watchdog.
- `cycles`  out  CW  number of RUN cycles in the last or current run.

## Operation
- States: IDLE, RSTC, RUN, FIN.
- All outputs are registered (Moore) and derive from the state and counters.
- Reset values: state=IDLE, `core_reset`=1, `core_en`=0, `busy`=0, `done`=0, `timeout`=0, `cycles`=0, reset-hold counter=0.
- **IDLE.** `core_reset`=1.
  - `req`=1 sampled → RSTC.
  - The reset-hold counter and `cycles` clear on this entry edge.
  - `timeout` clears on this entry edge.
- **RSTC.** `core_reset`=1 and `busy`=1.
  - The hold counter increments every edge.
  - After RST_CYC edges in RSTC → RUN.
  - `req`=0 sampled → IDLE.
- **RUN.** `core_reset`=0, `core_en`=1, `busy`=1.
  - `cycles` increments on every RUN edge, including the exit edge.
  - `core_done`=1 sampled → FIN, with `timeout`=0.
  - Otherwise, if `cycles`==TMO−1 → FIN, with `timeout`=1 (`cycles` becomes TMO).
  - `req`=0 sampled → IDLE (abort). Abort has the highest priority. No `done` is produced, and `cycles` keeps its partial count.
  - `core_done` and the watchdog on the same edge: done wins, so `timeout`=0.
- **FIN.** `done`=1, `core_en`=0, `core_reset`=0.
  - The core state is frozen so memory can be inspected.
  - `cycles` and `timeout` are held.
  - `req`=0 sampled → IDLE.
  - `core_done` is ignored in this state.
- `cycles` never wraps, because TMO ≤ 2^CW−1.
- Back-to-back runs need `req` low for at least one edge, so the controller passes through IDLE.
- `core_done` is ignored in IDLE and RSTC.

## Timing
- `req` rises before edge 0:
  - RSTC occupies edges 0..RST_CYC−1.
  - At edge RST_CYC the state becomes RUN.
  - `core_en` is first high in the cycle after edge RST_CYC.
  - `core_reset` falls at that same edge.
- `core_done` sampled high at the Nth RUN edge:
  - `done`=1 and `cycles`=N after that edge.
  - `core_en` falls at the same edge, so the core executes exactly N enabled cycles.
- Latency from `req` to `done` is RST_CYC+N edges.
- `req` falls:
  - `done` clears after the next edge.
  - `core_reset` rises after that same edge.
- Asynchronous reset mid-run: outputs go to reset values within the same cycle; the next `req` restarts from IDLE.

## Structure
- Package `run_seq_pkg` holds:
  - the state enum `run_state_t` (IDLE, RSTC, RUN, FIN);
  - the default localparams for CW, RST_CYC and TMO, shared with `top_level` and the bench.
- One sub-module, `run_cycle_ctr`, owns the CW-bit counter. It has clear, enable and terminal-count outputs, and is instantiated twice: once for the reset hold and once for `cycles`.
- The FSM lives in `run_sequencer`.

## Test plan
1. **Reset.** Assert `reset` mid-clock with no edge → `core_reset`=1, `core_en`=0, `busy`=0, `done`=0, `timeout`=0, `cycles`=0 immediately.
2. **Normal run.** RST_CYC=2; `req`=1 before edge 0; `core_done`=1 at the 10th RUN edge.
   - `core_reset`=1 through edge 1 and `core_en`=1 from edge 2.
   - `done`=1, `timeout`=0, `cycles`=10.
   - Drop `req` → `done`=0 and `core_reset`=1 one edge later.
3. **Watchdog.** TMO=20 and `core_done` held 0 → `done`=1, `timeout`=1, `cycles`=20, `core_en`=0.
4. **Simultaneous done and watchdog.** TMO=20 and `core_done`=1 exactly at the 20th RUN edge → `done`=1, `timeout`=0, `cycles`=20.
5. **Abort.** `req`=0 at RUN cycle 5 → IDLE next edge, `done` never asserts, `core_reset`=1, `cycles`=5.
   - Repeat with `req` dropped during RSTC → IDLE, `core_en` never asserts.
6. **Back-to-back and mid-run reset.**
   - Run 1 ends with `cycles`=7. `req` low for one edge, then high → `cycles`=0 after the RSTC entry edge; run 2 with N=3 reports 3.
   - Async `reset` during RUN → reset values at once, and a clean restart on the next `req`.
